// File: rtl/rs232_rx_ctrl.sv
// Purpose : RS-232 receive sequencer; finds the start bit, samples each bit at mid-bit,
//           shifts data in LSB first, checks the stop bit and strobes out the byte.
// Latency : rx_done_o rises BaudDiv/2 + (DataBits+1)*BaudDiv cycles after the first low rx_s
//           sample (+BaudDiv with parity); the rx_i to rx_s synchronizer adds 2 more cycles.
// Backpressure: none; the consumer must take data_o in the cycle rx_done_o is high.
//
// Optional feature macro: RS232_PARITY_EN (even-parity bit after the data, adds parity_err_o).
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        asynchronous reset, active-high
//   rx_i         serial line, idle high, asynchronous to clk_i
//   data_o       last correctly framed byte, LSB = first bit received
//   rx_done_o    one-cycle strobe, data_o updated this cycle
//   frame_err_o  one-cycle strobe, stop bit sampled low
//   busy_o       high whenever the receiver is not idle
//   parity_err_o one-cycle strobe alongside rx_done_o on parity mismatch (macro only)
module rs232_rx_ctrl #(
  parameter int BaudDiv  = 434,
  parameter int CntWidth = 9,
  parameter int DataBits = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                rx_i,
  output logic [DataBits-1:0] data_o,
  output logic                rx_done_o,
  output logic                frame_err_o,
`ifdef RS232_PARITY_EN
  output logic                parity_err_o,
`endif
  output logic                busy_o
);

  localparam int BitW = (DataBits > 1) ? $clog2(DataBits) : 1;
  localparam logic [CntWidth-1:0] BitEnd  = CntWidth'(BaudDiv - 1);
  localparam logic [CntWidth-1:0] HalfEnd = CntWidth'(BaudDiv / 2 - 1);
  localparam logic [BitW-1:0]     LastBit = BitW'(DataBits - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RS232_PARITY_EN
    PARITY,
`endif
    STOP,
    BRK
  } state_e;

  typedef enum logic [1:0] {
    CNT_CLR,
    CNT_HOLD,
    CNT_INC
  } cnt_op_e;

  state_e                state_q, state_n;
  cnt_op_e               cnt_op;
  logic                  rx_meta, rx_s;
  logic [CntWidth-1:0]   baud_cnt;
  logic [BitW-1:0]       bit_cnt;
  logic [DataBits-1:0]   shift_q;
  logic                  bit_tick, half_tick;
  logic                  bit_clr, bit_inc, shift_en, load_en;
  logic                  done_n, ferr_n;
`ifdef RS232_PARITY_EN
  logic                  par_q, par_en, perr_n;
`endif

  // Two-flop synchronizer; resets to the idle line level so reset release cannot fake a start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  assign bit_tick  = (baud_cnt == BitEnd);
  assign half_tick = (baud_cnt == HalfEnd);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      baud_cnt <= '0;
    end else begin
      unique case (cnt_op)
        CNT_CLR:  baud_cnt <= '0;
        CNT_INC:  baud_cnt <= baud_cnt + 1'b1;
        default:  baud_cnt <= baud_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt <= '0;
    end else if (bit_clr) begin
      bit_cnt <= '0;
    end else if (bit_inc) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // New bit enters at the MSB so that after DataBits shifts the first bit sits in the LSB.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= '0;
    end else if (shift_en) begin
      shift_q <= {rx_s, shift_q[DataBits-1:1]};
    end
  end

`ifdef RS232_PARITY_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      par_q <= 1'b0;
    end else if (par_en) begin
      par_q <= rx_s;
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    cnt_op   = CNT_INC;
    bit_clr  = 1'b0;
    bit_inc  = 1'b0;
    shift_en = 1'b0;
    load_en  = 1'b0;
    done_n   = 1'b0;
    ferr_n   = 1'b0;
`ifdef RS232_PARITY_EN
    par_en   = 1'b0;
    perr_n   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_op = CNT_CLR;
        if (!rx_s) state_n = START;
      end
      START: begin
        // Re-check the line half a bit in; a high line here means a glitch, not a start bit.
        if (half_tick) begin
          cnt_op = CNT_CLR;
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
            bit_clr = 1'b1;
          end
        end
      end
      DATA: begin
        if (bit_tick) begin
          cnt_op   = CNT_CLR;
          shift_en = 1'b1;
          if (bit_cnt == LastBit) begin
`ifdef RS232_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
`ifdef RS232_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          cnt_op  = CNT_CLR;
          par_en  = 1'b1;
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          cnt_op = CNT_CLR;
          if (rx_s) begin
            load_en = 1'b1;
            done_n  = 1'b1;
`ifdef RS232_PARITY_EN
            perr_n  = (^shift_q) ^ par_q;
`endif
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = BRK;
          end
        end
      end
      BRK: begin
        // A line held low must return high before another start bit can be recognised.
        cnt_op = CNT_HOLD;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_o       <= '0;
      rx_done_o    <= 1'b0;
      frame_err_o  <= 1'b0;
      busy_o       <= 1'b0;
`ifdef RS232_PARITY_EN
      parity_err_o <= 1'b0;
`endif
    end else begin
      if (load_en) data_o <= shift_q;
      rx_done_o    <= done_n;
      frame_err_o  <= ferr_n;
      busy_o       <= (state_n != IDLE);
`ifdef RS232_PARITY_EN
      parity_err_o <= perr_n;
`endif
    end
  end

endmodule

// File: tb/tb_rs232_rx_ctrl.sv
// Bench for rs232_rx_ctrl with BaudDiv=16, DataBits=8.
// A timeline model predicts every output from the bit sampling schedule; directed
// checks pin latency, data values and strobe counts.
module tb_rs232_rx_ctrl;

  localparam int B  = 16;
  localparam int H  = B / 2;
`ifdef RS232_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  localparam int M_IDLE  = 0;
  localparam int M_FRAME = 1;
  localparam int M_BRK   = 2;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       rx_i;
  logic [7:0] data_o;
  logic       rx_done_o, frame_err_o, busy_o;
`ifdef RS232_PARITY_EN
  logic       parity_err_o;
`endif

  rs232_rx_ctrl #(.BaudDiv(B), .CntWidth(5), .DataBits(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .rx_done_o   (rx_done_o),
    .frame_err_o (frame_err_o),
`ifdef RS232_PARITY_EN
    .parity_err_o(parity_err_o),
`endif
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: line sampled 2 edges late, bits at fixed offsets ----------
  int         cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] dly;
  int         m_e, m_t0, m_mode;
  logic [7:0] m_byte;
  logic       exp_busy, exp_done, exp_ferr;
  logic [7:0] exp_data;
`ifdef RS232_PARITY_EN
  logic       m_par, exp_perr;
`endif

  // Index of the frame bit sampled at edge e (0..7 data, 8 parity/stop...), -1 if none.
  function automatic int slot(input int e, input int t0);
    int r;
    r = e - t0 - H;
    if (r > 0 && (r % B) == 0) return r / B - 1;
    return -1;
  endfunction

  int sl;
  assign sl = slot(m_e, m_t0);

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      dly      <= 2'b11;
      m_e      <= 0;
      m_t0     <= 0;
      m_mode   <= M_IDLE;
      m_byte   <= '0;
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
      exp_ferr <= 1'b0;
      exp_data <= '0;
`ifdef RS232_PARITY_EN
      m_par    <= 1'b0;
      exp_perr <= 1'b0;
`endif
    end else begin
      dly      <= {dly[0], rx_i};
      m_e      <= m_e + 1;
      exp_done <= 1'b0;
      exp_ferr <= 1'b0;
`ifdef RS232_PARITY_EN
      exp_perr <= 1'b0;
`endif
      case (m_mode)
        M_IDLE: if (!dly[1]) begin
          m_t0     <= m_e;
          m_mode   <= M_FRAME;
          exp_busy <= 1'b1;
        end
        M_FRAME: begin
          if (m_e - m_t0 == H) begin
            if (dly[1]) begin
              m_mode   <= M_IDLE;
              exp_busy <= 1'b0;
            end
          end else if (sl >= 0 && sl < 8) begin
            m_byte[sl[2:0]] <= dly[1];
`ifdef RS232_PARITY_EN
          end else if (sl == 8) begin
            m_par <= dly[1];
`endif
          end else if (sl == NB) begin
            if (dly[1]) begin
              exp_done <= 1'b1;
              exp_data <= m_byte;
`ifdef RS232_PARITY_EN
              exp_perr <= (^m_byte) ^ m_par;
`endif
              m_mode   <= M_IDLE;
              exp_busy <= 1'b0;
            end else begin
              exp_ferr <= 1'b1;
              m_mode   <= M_BRK;
            end
          end
        end
        default: if (dly[1]) begin
          m_mode   <= M_IDLE;
          exp_busy <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (!rst_i) begin
      check("busy_o", busy_o, exp_busy);
      check("rx_done_o", rx_done_o, exp_done);
      check("frame_err_o", frame_err_o, exp_ferr);
      check("data_o", data_o, exp_data);
`ifdef RS232_PARITY_EN
      check("parity_err_o", parity_err_o, exp_perr);
`endif
    end
  end

  // ---------------- event monitor for directed checks ----------------
  int         done_cnt = 0, ferr_cnt = 0, busy_cyc = 0, last_done_cyc = 0;
  logic [7:0] done_hist[$];
`ifdef RS232_PARITY_EN
  int         perr_cnt = 0, perr_with_done = 0;
`endif
  always @(negedge clk) begin
    if (rx_done_o) begin
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= cyc;
      done_hist.push_back(data_o);
    end
    if (frame_err_o) ferr_cnt <= ferr_cnt + 1;
    if (busy_o) busy_cyc <= busy_cyc + 1;
`ifdef RS232_PARITY_EN
    if (parity_err_o) perr_cnt <= perr_cnt + 1;
    if (parity_err_o && rx_done_o) perr_with_done <= perr_with_done + 1;
`endif
  end

  // ---------------- stimulus ----------------
  int start_cyc;

  task automatic drive_bit(input logic v);
    rx_i = v;
    repeat (B) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef RS232_PARITY_EN
    drive_bit(par_b);
`else
    if (par_b) rx_i = 1'b1;
`endif
    drive_bit(stop_b);
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  int d0, f0, b0, h0;

  initial begin
    rst_i = 1'b1;
    rx_i  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset busy_o", busy_o, 0);
    check("reset rx_done_o", rx_done_o, 0);
    check("reset frame_err_o", frame_err_o, 0);
    check("reset data_o", data_o, 0);
    rst_i = 1'b0;
    idle(10);

    // 0xA5: first rx_s low sample is 3 edges after the drive, done 152 edges later.
    d0 = done_cnt;
    f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(40);
    check("a5 done count", done_cnt - d0, 1);
    check("a5 data", done_hist[done_hist.size()-1], 8'hA5);
    check("a5 latency", last_done_cyc - start_cyc, 155);
    check("a5 no frame err", ferr_cnt - f0, 0);

    // Back-to-back 0x00, 0xFF with no idle gap.
    h0 = done_hist.size();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(40);
    check("b2b done count", done_hist.size() - h0, 2);
    check("b2b first", done_hist[h0], 8'h00);
    check("b2b second", done_hist[h0+1], 8'hFF);

    // 4-cycle glitch: START lasts half a bit, then back to IDLE silently.
    d0 = done_cnt;
    f0 = ferr_cnt;
    b0 = busy_cyc;
    rx_i = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    check("glitch no done", done_cnt - d0, 0);
    check("glitch no ferr", ferr_cnt - f0, 0);
    check("glitch busy seen", (busy_cyc - b0) > 0, 1);
    check("glitch busy <= 9", (busy_cyc - b0) <= 9, 1);

    // 0x3C with a low stop bit, line kept low 64 more cycles.
    d0 = done_cnt;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    rx_i = 1'b0;
    repeat (64) @(negedge clk);
    check("break busy held", busy_o, 1);
    idle(40);
    check("ferr count", ferr_cnt - f0, 1);
    check("ferr no done", done_cnt - d0, 0);
    check("ferr data kept", data_o, 8'hFF);

    d0 = done_cnt;
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(40);
    check("after break done", done_cnt - d0, 1);
    check("after break data", data_o, 8'h5A);

    // Reset in the middle of bit 4 of 0x81.
    d0 = done_cnt;
    rx_i = 1'b0;
    repeat (B) @(negedge clk);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rx_i = 1'b0;
    repeat (H) @(negedge clk);
    rst_i = 1'b1;
    rx_i  = 1'b1;
    #1;
    check("midreset busy_o", busy_o, 0);
    check("midreset data_o", data_o, 0);
    check("midreset rx_done_o", rx_done_o, 0);
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    idle(20);
    check("midreset no done", done_cnt - d0, 0);
    send_frame(8'h81, 1'b1, 1'b1);
    idle(40);
    check("post-reset done", done_cnt - d0, 1);
    check("post-reset data", data_o, 8'h81);

`ifdef RS232_PARITY_EN
    // Even parity: 0x07 has three ones, so the parity bit must be 1.
    d0 = done_cnt;
    b0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    idle(40);
    check("par ok done", done_cnt - d0, 1);
    check("par ok no perr", perr_cnt - b0, 0);
    d0 = done_cnt;
    b0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(40);
    check("par bad done", done_cnt - d0, 1);
    check("par bad perr", perr_cnt - b0, 1);
    check("par bad with done", perr_with_done, 1);
    check("par bad data", data_o, 8'h07);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
